// File: rtl/clk_rate_monitor.sv
// Slow-clock receiver: synchronizes clk_in into the clk domain, emits rise/fall ticks,
// measures the rise-to-rise period in clk cycles and reports lock and loss of clock.
module clk_rate_monitor #(
  parameter int CNT_W       = 28,
  parameter int TIMEOUT_CYC = 2**28 - 1,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int               MW        = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
  localparam logic [MW-1:0]    LOCK_V    = MW'(LOCK_COUNT);
  localparam logic [CNT_W:0]   TOL_V     = (CNT_W + 1)'(TOL);

  typedef enum logic [1:0] {ST_IDLE, ST_FIRST, ST_MEASURE, ST_LOCKED} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_s1, r_s2, r_s3;
  logic [1:0]            r_prime;
  logic                  r_rise_tick, r_fall_tick;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_period, w_period_nxt;
  logic [MW-1:0]         r_match, w_match_nxt, w_match_inc;
  logic                  r_valid, w_valid_nxt;
  logic                  r_locked, w_locked_nxt;
  logic                  r_timeout, w_timeout_nxt;
  logic                  w_armed, w_rise, w_fall, w_in_tol;
  logic signed [CNT_W:0] w_diff;
  logic [CNT_W:0]        w_abs;

  // Edge detection stays masked until s1..s3 hold post-reset samples.
  assign w_armed = (r_prime == 2'd3);
  assign w_rise  = w_armed &  r_s2 & ~r_s3;
  assign w_fall  = w_armed & ~r_s2 &  r_s3;

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_prime     <= 2'd0;
      r_rise_tick <= 1'b0;
      r_fall_tick <= 1'b0;
    end else begin
      r_s1        <= clk_in;
      r_s2        <= r_s1;
      r_s3        <= r_s2;
      r_rise_tick <= w_rise;
      r_fall_tick <= w_fall;
      if (!w_armed) r_prime <= r_prime + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                             r_cnt <= '0;
    else if (w_rise)                       r_cnt <= CNT_W'(1);
    else if (r_cnt != {CNT_W{1'b1}})       r_cnt <= r_cnt + CNT_W'(1);
  end

  // Signed difference one bit wider than the counter so it never wraps.
  assign w_diff      = $signed({1'b0, r_cnt}) - $signed({1'b0, r_period});
  assign w_abs       = $unsigned(w_diff[CNT_W] ? -w_diff : w_diff);
  assign w_in_tol    = (w_abs <= TOL_V);
  assign w_match_inc = r_match + MW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_period  <= '0;
      r_match   <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_period  <= w_period_nxt;
      r_match   <= w_match_nxt;
      r_valid   <= w_valid_nxt;
      r_locked  <= w_locked_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_period_nxt  = r_period;
    w_match_nxt   = r_match;
    w_valid_nxt   = r_valid;
    w_locked_nxt  = r_locked;
    w_timeout_nxt = r_timeout;
    if (w_rise) begin
      unique case (r_state)
        ST_IDLE: begin
          w_timeout_nxt = 1'b0;
          w_state_nxt   = ST_FIRST;
        end
        ST_FIRST: begin
          w_period_nxt = r_cnt;
          w_valid_nxt  = 1'b1;
          w_match_nxt  = '0;
          w_state_nxt  = ST_MEASURE;
        end
        ST_MEASURE: begin
          w_period_nxt = r_cnt;
          if (w_in_tol) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc == LOCK_V) begin
              w_locked_nxt = 1'b1;
              w_state_nxt  = ST_LOCKED;
            end
          end else begin
            w_match_nxt = '0;
          end
        end
        ST_LOCKED: begin
          w_period_nxt = r_cnt;
          if (!w_in_tol) begin
            w_locked_nxt = 1'b0;
            w_match_nxt  = '0;
            w_state_nxt  = ST_MEASURE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (r_cnt == TIMEOUT_V) begin
      // Loss of slow clock; period keeps the last measurement for diagnostics.
      w_timeout_nxt = 1'b1;
      w_locked_nxt  = 1'b0;
      w_valid_nxt   = 1'b0;
      w_match_nxt   = '0;
      w_state_nxt   = ST_IDLE;
    end
  end

  assign rise_tick    = r_rise_tick;
  assign fall_tick    = r_fall_tick;
  assign period       = r_period;
  assign period_valid = r_valid;
  assign locked       = r_locked;
  assign timeout      = r_timeout;

endmodule
